pe_tile_sequencer: RTL and testbench

Tile-level controller in front of one PE. It accepts a tile descriptor (number of accumulation passes, number of psum outputs per pass) and issues one pass instruction per pass to the PE. It then counts the PE's psum handshakes for that pass: intermediate passes are absorbed, and final-pass psums are forwarded downstream. It sits between the array-level dispatcher and the PE's `Inst`/`Psum` ports and guarantees that PPAD accumulation order is never violated.

---
 rtl/pe_tile_sequencer_pkg.sv | 25 ++
 rtl/pe_tile_sequencer_if.sv | 30 +++
 rtl/pe_tile_sequencer_pass_counter.sv | 37 +++
 rtl/pe_tile_sequencer.sv | 112 +++++++++++
 tb/tb_pe_tile_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_tile_sequencer_pkg.sv
// Shared types for the PE tile sequencer: counter width, PE geometry,
// the pass instruction word and the controller state encoding.
package pe_tile_sequencer_pkg;

  localparam int CNTWD   = 8;
  localparam int PEROW   = 4;
  localparam int PSUMDWD = 16;

  typedef logic [CNTWD-1:0] cnt_t;
  typedef logic [PEROW-1:0][PSUMDWD-1:0] PsumVec;

  typedef struct packed {
    logic             first;
    logic             last;
    logic [CNTWD-1:0] pass_idx;
  } SeqInst;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } SeqState;

endpackage

// File: rtl/pe_tile_sequencer_if.sv
// Handshake bundle between dispatcher, sequencer, PE and downstream sink.
// master = sequencer side, slave = environment (dispatcher/PE/sink) side.
interface pe_tile_sequencer_if;
  import pe_tile_sequencer_pkg::*;

  logic   Tile_rdy;
  logic   Tile_ack;
  cnt_t   i_tile_npass;
  cnt_t   i_tile_nout;
  logic   PEinst_rdy;
  logic   PEinst_ack;
  SeqInst o_PEinst;
  logic   Psum_rdy;
  logic   Psum_ack;
  PsumVec i_Psum;
  logic   Out_rdy;
  logic   Out_ack;
  PsumVec o_Out;

  modport master (
    input  Tile_rdy, i_tile_npass, i_tile_nout, PEinst_ack, Psum_rdy, i_Psum, Out_ack,
    output Tile_ack, PEinst_rdy, o_PEinst, Psum_ack, Out_rdy, o_Out
  );

  modport slave (
    output Tile_rdy, i_tile_npass, i_tile_nout, PEinst_ack, Psum_rdy, i_Psum, Out_ack,
    input  Tile_ack, PEinst_rdy, o_PEinst, Psum_ack, Out_rdy, o_Out
  );

endinterface

// File: rtl/pe_tile_sequencer_pass_counter.sv
// Loadable up-counter: i_load latches the limit and zeroes the count,
// o_tc flags the last value before the limit (count == limit-1).
module pe_tile_sequencer_pass_counter
  import pe_tile_sequencer_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  cnt_t i_limit,
  input  logic i_clr,
  input  logic i_inc,
  output cnt_t o_cnt,
  output logic o_tc
);

  cnt_t r_cnt;
  cnt_t r_limit;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt   <= '0;
      r_limit <= '0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_limit <= i_limit;
    end else if (i_clr) begin
      r_cnt   <= '0;
    end else if (i_inc) begin
      r_cnt   <= r_cnt + cnt_t'(1);
    end
  end

  // A zero limit never reaches this module's consumer, so limit-1 wrapping is harmless.
  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == r_limit - cnt_t'(1));

endmodule

// File: rtl/pe_tile_sequencer.sv
// Tile controller in front of one PE: issues one instruction per pass and
// absorbs intermediate-pass psums, forwarding only the final pass downstream.
module pe_tile_sequencer
  import pe_tile_sequencer_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  pe_tile_sequencer_if.master   bus,
  output logic                  o_done,
  output logic                  o_busy
);

  SeqState r_state;
  SeqState w_state_next;
  logic    r_alive;

  logic w_tile_xfer;
  logic w_tile_zero;
  logic w_inst_xfer;
  logic w_psum_xfer;
  logic w_pass_end;
  logic w_last_pass;
  logic w_out_tc;
  cnt_t w_pass_idx;
  cnt_t w_out_cnt;
  logic w_unused_out_cnt;

  assign w_tile_xfer = bus.Tile_rdy & bus.Tile_ack;
  assign w_tile_zero = (bus.i_tile_npass == '0) | (bus.i_tile_nout == '0);
  assign w_inst_xfer = bus.PEinst_rdy & bus.PEinst_ack;
  assign w_psum_xfer = bus.Psum_rdy & bus.Psum_ack;
  assign w_pass_end  = w_psum_xfer & w_out_tc;

  pe_tile_sequencer_pass_counter u_pass_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_tile_xfer),
    .i_limit (bus.i_tile_npass),
    .i_clr   (1'b0),
    .i_inc   (w_pass_end & ~w_last_pass),
    .o_cnt   (w_pass_idx),
    .o_tc    (w_last_pass)
  );

  pe_tile_sequencer_pass_counter u_out_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_tile_xfer),
    .i_limit (bus.i_tile_nout),
    .i_clr   (w_pass_end),
    .i_inc   (w_psum_xfer),
    .o_cnt   (w_out_cnt),
    .o_tc    (w_out_tc)
  );

  assign w_unused_out_cnt = ^w_out_cnt;

  // Holds Tile_ack low until the first clock after reset release.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_alive <= 1'b0;
    else        r_alive <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_tile_xfer) w_state_next = w_tile_zero ? DONE : ISSUE;
      ISSUE:   if (w_inst_xfer) w_state_next = COLLECT;
      COLLECT: if (w_pass_end)  w_state_next = w_last_pass ? DONE : ISSUE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.Tile_ack   = 1'b0;
    bus.PEinst_rdy = 1'b0;
    bus.o_PEinst   = '0;
    bus.Psum_ack   = 1'b0;
    bus.Out_rdy    = 1'b0;
    o_done         = 1'b0;
    case (r_state)
      IDLE:  bus.Tile_ack = r_alive;
      ISSUE: begin
        bus.PEinst_rdy        = 1'b1;
        bus.o_PEinst.first    = (w_pass_idx == '0);
        bus.o_PEinst.last     = w_last_pass;
        bus.o_PEinst.pass_idx = w_pass_idx;
      end
      COLLECT: begin
        // Final pass is a bubble-free pass-through; earlier passes are already in PPAD.
        if (w_last_pass) begin
          bus.Out_rdy  = bus.Psum_rdy;
          bus.Psum_ack = bus.Out_ack;
        end else begin
          bus.Psum_ack = 1'b1;
        end
      end
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_Out = bus.i_Psum;
  assign o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Randomized bench: a transaction-level queue of expected PE events per tile
// (instruction, then nout psums, per pass) is checked cycle by cycle.
module tb_pe_tile_sequencer;
  import pe_tile_sequencer_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic o_done;
  logic o_busy;

  pe_tile_sequencer_if bus();

  pe_tile_sequencer dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .bus    (bus),
    .o_done (o_done),
    .o_busy (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct {
    bit is_inst;
    bit first;
    bit last;
    int idx;
    bit fwd;
  } ev_t;

  ev_t exp_q[$];

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tile_ack"},   bus.Tile_ack,   0);
    chk({tag, "_inst_rdy"},   bus.PEinst_rdy, 0);
    chk({tag, "_psum_ack"},   bus.Psum_ack,   0);
    chk({tag, "_out_rdy"},    bus.Out_rdy,    0);
    chk({tag, "_done"},       o_done,         0);
    chk({tag, "_busy"},       o_busy,         0);
    chk({tag, "_inst_word"},  bus.o_PEinst,   0);
  endtask

  task automatic drive_idle();
    bus.Tile_rdy   = 1'b0;
    bus.PEinst_ack = 1'b0;
    bus.Psum_rdy   = 1'b0;
    bus.Out_ack    = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("rel_tile_ack_low", bus.Tile_ack, 0);
    @(negedge i_clk);
    #1;
    chk("rel_tile_ack_high", bus.Tile_ack, 1);
  endtask

  task automatic run_tile(input int npass, input int nout, input bit eager,
                          input bit stall, input int abort_pass);
    int  budget;
    int  cyc;
    int  n_inst, n_fwd, n_absorb, stall_left;
    bit  accepted, done_seen, finished, aborted, psum_hold, stall_used;
    bit  head_inst, head_psum, head_fwd;
    ev_t ev;
    SeqInst exp_inst;

    exp_q.delete();
    if (npass > 0 && nout > 0) begin
      for (int p = 0; p < npass; p++) begin
        ev = '{is_inst: 1, first: (p == 0), last: (p == npass - 1), idx: p, fwd: 0};
        exp_q.push_back(ev);
        for (int j = 0; j < nout; j++) begin
          ev = '{is_inst: 0, first: 0, last: 0, idx: p, fwd: (p == npass - 1)};
          exp_q.push_back(ev);
        end
      end
    end

    budget = 20 * npass * (nout + 2) + 40;
    n_inst = 0; n_fwd = 0; n_absorb = 0; stall_left = 0;
    accepted = 0; done_seen = 0; finished = 0; aborted = 0;
    psum_hold = 0; stall_used = 0;
    bus.i_tile_npass = cnt_t'(npass);
    bus.i_tile_nout  = cnt_t'(nout);

    for (cyc = 0; cyc < budget; cyc++) begin
      @(negedge i_clk);
      head_inst = (exp_q.size() > 0) && exp_q[0].is_inst;
      head_psum = (exp_q.size() > 0) && !exp_q[0].is_inst;
      head_fwd  = head_psum && exp_q[0].fwd;

      bus.Tile_rdy   = !accepted;
      bus.PEinst_ack = eager ? 1'b1 : 1'($urandom_range(0, 1));
      if (!psum_hold) begin
        bus.Psum_rdy = eager ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.i_Psum   = {$urandom, $urandom};
        psum_hold    = bus.Psum_rdy;
      end
      if (stall && head_fwd && !stall_used && bus.Psum_rdy) begin
        stall_used = 1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        bus.Out_ack = 1'b0;
        stall_left--;
      end else begin
        bus.Out_ack = eager ? 1'b1 : ($urandom_range(0, 2) != 0);
      end

      if (abort_pass >= 0 && head_psum && exp_q[0].idx == abort_pass) begin
        bus.Psum_rdy = 1'b1;
        bus.Out_ack  = 1'b1;
        #2 i_rst = 1'b0;
        #1 check_reset_outputs("midtile");
        aborted = 1;
        break;
      end

      #1;
      if (done_seen) begin
        chk("tile_ack_after_done", bus.Tile_ack, 1);
        chk("busy_after_done",     o_busy,       0);
        chk("done_one_cycle",      o_done,       0);
        finished = 1;
        break;
      end

      chk("tile_ack", bus.Tile_ack,   !accepted);
      chk("busy",     o_busy,         accepted);
      chk("inst_rdy", bus.PEinst_rdy, accepted && head_inst);
      if (bus.PEinst_rdy && head_inst) begin
        exp_inst.first    = exp_q[0].first;
        exp_inst.last     = exp_q[0].last;
        exp_inst.pass_idx = cnt_t'(exp_q[0].idx);
        chk("inst_word", bus.o_PEinst, exp_inst);
      end
      chk("out_rdy",  bus.Out_rdy,  bus.Psum_rdy && head_fwd);
      chk("psum_ack", bus.Psum_ack, head_psum && (head_fwd ? bus.Out_ack : 1'b1));
      if (head_fwd) chk("out_data", bus.o_Out, bus.i_Psum);
      chk("done", o_done, accepted && exp_q.size() == 0);

      if (bus.Psum_rdy && bus.Psum_ack) psum_hold = 0;
      if (!accepted && bus.Tile_rdy && bus.Tile_ack) begin
        accepted = 1;
      end else if (head_inst && bus.PEinst_rdy && bus.PEinst_ack) begin
        void'(exp_q.pop_front());
        n_inst++;
      end else if (head_psum && bus.Psum_rdy && bus.Psum_ack) begin
        if (head_fwd) n_fwd++;
        else n_absorb++;
        void'(exp_q.pop_front());
      end
      if (o_done) done_seen = 1;
    end

    if (aborted) begin
      @(negedge i_clk);
      drive_idle();
      release_reset();
      $display("tile npass=%0d nout=%0d aborted by reset in pass %0d insts=%0d absorbed=%0d",
               npass, nout, abort_pass, n_inst, n_absorb);
    end else begin
      if (!finished) chk("tile_timeout", 0, 1);
      drive_idle();
      $display("tile npass=%0d nout=%0d insts=%0d forwarded=%0d absorbed=%0d cycles=%0d",
               npass, nout, n_inst, n_fwd, n_absorb, cyc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rp, rn;
    bus.Tile_rdy     = 1'b0;
    bus.i_tile_npass = '0;
    bus.i_tile_nout  = '0;
    bus.PEinst_ack   = 1'b0;
    bus.Psum_rdy     = 1'b1;
    bus.i_Psum       = '0;
    bus.Out_ack      = 1'b1;
    #2 i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    #1 check_reset_outputs("por");
    drive_idle();
    release_reset();

    run_tile(1, 4, 1, 0, -1);
    run_tile(3, 2, 0, 0, -1);
    run_tile(2, 3, 0, 1, -1);
    run_tile(0, 5, 1, 0, -1);
    run_tile(3, 2, 0, 0, 1);
    run_tile(1, 1, 0, 0, -1);
    run_tile(255, 1, 0, 0, -1);
    for (int k = 0; k < 10; k++) begin
      rp = $urandom_range(0, 5);
      rn = $urandom_range(0, 5);
      run_tile(rp, rn, 0, 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
